// File: rtl/mips_pkg.sv
// Shared definitions for the MiniMIPS fetch path: instruction/immediate widths,
// the default halt encoding and the fetch sequencer state type.
package mips_pkg;

    localparam int INSTR_W = 16;
    localparam int IMM_W   = 6;

    localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC selection for the fetch unit: sequential PC + 1, or PC + 1 plus the
// sign-extended branch Imm when the accepted branch is taken. Sums wrap mod 2^PC_W.
module mips_next_pc
    import mips_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             branch_taken,
    input  logic [IMM_W-1:0] branch_imm,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] pc_seq;

    assign imm_sext = {{(PC_W-IMM_W){branch_imm[IMM_W-1]}}, branch_imm};
    assign pc_seq   = pc + PC_W'(1);
    assign next_pc  = branch_taken ? (pc_seq + imm_sext) : pc_seq;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, reads the synchronous instruction ROM
// and offers one instruction at a time to the datapath over valid/ready.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                 PC_W       = 8,
    parameter logic [PC_W-1:0]    RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   branch_imm,
    output logic [PC_W-1:0]    pc_out,
    output logic               busy,
    output logic               done
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_target;
    logic [PC_W-1:0] branch_pc;
    logic            load_pc;
    logic            handshake;

    assign handshake = (state == ISSUE) && instr_valid && instr_ready;

    mips_next_pc #(.PC_W(PC_W)) u_next_pc (
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .next_pc      (branch_pc)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        pc_target  = pc;
        load_pc    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    pc_target  = RESET_PC;
                    load_pc    = 1'b1;
                end
            end
            FETCH: begin
                state_next = (imem_rdata == HALT_INSTR) ? HALT : ISSUE;
            end
            ISSUE: begin
                if (handshake) begin
                    state_next = FETCH;
                    pc_target  = branch_pc;
                    load_pc    = 1'b1;
                end
            end
            HALT: begin
                if (start) begin
                    state_next = FETCH;
                    pc_target  = RESET_PC;
                    load_pc    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The ROM sees the new target in the cycle that decides it, so its data is
    // ready during FETCH and an instruction can issue every second cycle.
    assign imem_addr = pc_target;
    assign pc_out    = pc;
    assign busy      = (state == FETCH) || (state == ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (load_pc) begin
                pc <= pc_target;
            end
            if (state == FETCH) begin
                instr_out   <= imem_rdata;
                instr_valid <= (imem_rdata != HALT_INSTR);
                if (imem_rdata == HALT_INSTR) begin
                    done <= 1'b1;
                end
            end
            if (handshake) begin
                instr_valid <= 1'b0;
            end
            if ((state == HALT) && start) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: a bench-side PC model pushes the
// expected (pc, instruction) of every fetch; results are popped as the DUT issues them.
module tb_mips_fetch_unit;

    localparam logic [15:0] HALT = 16'hFFFF;
    localparam logic [7:0]  RPC  = 8'd0;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [5:0]  branch_imm;
    logic [7:0]  pc_out;
    logic        busy;
    logic        done;

    logic [15:0] rom [256];
    exp_t        sb [$];
    logic [7:0]  cur_pc;
    logic [15:0] cur_instr;
    int          checks   = 0;
    int          failures = 0;
    int          waited;

    mips_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .pc_out       (pc_out),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= rom[imem_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_expect(input logic [7:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = rom[pc];
        sb.push_back(e);
    endtask

    task automatic await_next(input string tag, output int n);
        exp_t e;
        n = 0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && !done && n < 12);
        if (e.instr == HALT) begin
            check({tag, "_done"}, 32'(done), 32'd1);
            check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        end else begin
            check({tag, "_valid"}, 32'(instr_valid), 32'd1);
            check({tag, "_instr"}, 32'(instr_out), 32'(e.instr));
            check({tag, "_pc"}, 32'(pc_out), 32'(e.pc));
            cur_pc    = e.pc;
            cur_instr = e.instr;
        end
    endtask

    task automatic do_start(input string tag);
        int w;
        start = 1'b1;
        push_expect(RPC);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_addr"}, 32'(imem_addr), 32'(RPC));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        await_next(tag, w);
        check({tag, "_latency"}, 32'(w + 1), 32'd2);
    endtask

    task automatic accept(input string tag, input logic tk, input logic [5:0] imm);
        logic [7:0] sx;
        logic [7:0] nxt;
        int w;
        sx  = {{2{imm[5]}}, imm};
        nxt = cur_pc + 8'd1 + (tk ? sx : 8'd0);
        instr_ready  = 1'b1;
        branch_taken = tk;
        branch_imm   = imm;
        @(negedge clk);
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 6'($urandom);
        check({tag, "_next_addr"}, 32'(imem_addr), 32'(nxt));
        check({tag, "_fetch_valid"}, 32'(instr_valid), 32'd0);
        push_expect(nxt);
        await_next(tag, w);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hA000 | 16'(i);
        rom[0] = 16'h1234;
        rom[1] = 16'h2345;
        rom[2] = HALT;

        reset        = 1'b1;
        start        = 1'b0;
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = '0;
        #12;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_out", 32'(instr_out), 32'd0);
        check("rst_pc", 32'(pc_out), 32'(RPC));
        check("rst_addr", 32'(imem_addr), 32'(RPC));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reach ISSUE at PC 3, then reset asynchronously in the middle of it.
        do_start("t1_start");
        accept("t1_br", 1'b1, 6'd2);
        #2 reset = 1'b1;
        #1;
        check("t1_rst_valid", 32'(instr_valid), 32'd0);
        check("t1_rst_pc", 32'(pc_out), 32'(RPC));
        check("t1_rst_addr", 32'(imem_addr), 32'(RPC));
        check("t1_rst_out", 32'(instr_out), 32'd0);
        check("t1_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();

        // Free-running stream with ready held high, ending on the halt word.
        instr_ready = 1'b1;
        do_start("t2_start");
        push_expect(8'd1);
        await_next("t2_i1", waited);
        check("t2_gap1", 32'(waited), 32'd2);
        push_expect(8'd2);
        await_next("t2_halt", waited);
        check("t2_gap2", 32'(waited), 32'd2);
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_halt_valid", 32'(instr_valid), 32'd0);
        check("t2_halt_busy", 32'(busy), 32'd0);
        check("t2_halt_done", 32'(done), 32'd1);

        // Restart from HALT.
        do_start("t6_restart");

        // Stall in ISSUE with branch noise and a start pulse.
        for (int c = 0; c < 5; c++) begin
            branch_taken = 1'($urandom_range(0, 1));
            branch_imm   = 6'($urandom);
            start        = (c == 2);
            @(negedge clk);
            start = 1'b0;
            check("t4_stall_instr", 32'(instr_out), 32'(cur_instr));
            check("t4_stall_pc", 32'(pc_out), 32'(cur_pc));
            check("t4_stall_valid", 32'(instr_valid), 32'd1);
            check("t4_stall_busy", 32'(busy), 32'd1);
        end
        branch_taken = 1'b0;

        accept("t4_seq", 1'b0, 6'h3F);
        accept("t5_back_wrap", 1'b1, 6'b111100);
        accept("t5_seq_255", 1'b0, 6'h00);
        accept("t5_fwd_wrap", 1'b0, 6'h1F);
        accept("t3_to4", 1'b1, 6'd3);
        accept("t3_neg3_halt", 1'b1, 6'b111101);
        check("t3_halt_busy", 32'(busy), 32'd0);

        do_start("t3_restart");
        accept("t3_to4b", 1'b1, 6'd3);
        accept("t3_pos5", 1'b1, 6'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
